// File: rtl/minmax_tracker.sv
// Running global min/max over a frame of N (min,max) pairs from the sorter stage.
// Results and range are final when the one-cycle done pulse is high, then held until the next start.
module minmax_tracker #(
  parameter int w = 6,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [w-1:0] in_min,
  input  logic [w-1:0] in_max,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] g_min,
  output logic [w-1:0] g_max,
  output logic [w-1:0] range,
  output logic [7:0]   count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t       state, state_nxt;
  logic [w-1:0] lo, hi, nxt_min, nxt_max;
  logic         last;

  // Order the incoming pair first so an unordered pair cannot corrupt either bound.
  always_comb begin
    lo      = (in_min < in_max) ? in_min : in_max;
    hi      = (in_min < in_max) ? in_max : in_min;
    nxt_min = (lo < g_min) ? lo : g_min;
    nxt_max = (hi > g_max) ? hi : g_max;
  end

  assign last = in_valid && (count == 8'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACCUM);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      g_min <= '1;
      g_max <= '0;
      range <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          g_min <= '1;
          g_max <= '0;
          count <= '0;
        end
        ACCUM: if (in_valid) begin
          g_min <= nxt_min;
          g_max <= nxt_max;
          count <= count + 8'd1;
          // range lands on the same edge as the last pair, so done sees final values
          if (last) range <= nxt_max - nxt_min;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Bench for minmax_tracker: an N=4 and an N=1 instance share stimulus; a frame-level
// model recomputes min/max/range from the list of accepted values every cycle.
module tb_minmax_tracker;
  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [5:0] in_min, in_max;

  logic       busy4, done4, busy1, done1;
  logic [5:0] gmin4, gmax4, rng4, gmin1, gmax1, rng1;
  logic [7:0] cnt4, cnt1;

  int checks = 0;
  int fails  = 0;

  // per-instance model: 0 -> N=4, 1 -> N=1
  bit in_frame[2];
  bit done_exp[2];
  int nvals[2];
  int vals[2][16];
  int rng_exp[2];

  always #5 clk = ~clk;

  minmax_tracker #(.w(6), .N(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_min(in_min), .in_max(in_max), .busy(busy4), .done(done4),
    .g_min(gmin4), .g_max(gmax4), .range(rng4), .count(cnt4));

  minmax_tracker #(.w(6), .N(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_min(in_min), .in_max(in_max), .busy(busy1), .done(done1),
    .g_min(gmin1), .g_max(gmax1), .range(rng1), .count(cnt1));

  function automatic int fmin(input int k);
    int m = 63;
    for (int i = 0; i < nvals[k]; i++) if (vals[k][i] < m) m = vals[k][i];
    return m;
  endfunction

  function automatic int fmax(input int k);
    int m = 0;
    for (int i = 0; i < nvals[k]; i++) if (vals[k][i] > m) m = vals[k][i];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int k, input int n, input bit r, input bit s, input bit v,
                       input int a, input int b);
    if (!r) begin
      in_frame[k] = 0; done_exp[k] = 0; nvals[k] = 0; rng_exp[k] = 0;
    end else if (done_exp[k]) begin
      done_exp[k] = 0;
    end else if (!in_frame[k]) begin
      if (s) begin in_frame[k] = 1; nvals[k] = 0; end
    end else if (v) begin
      vals[k][nvals[k]] = a; vals[k][nvals[k] + 1] = b; nvals[k] += 2;
      if (nvals[k] == 2 * n) begin
        in_frame[k] = 0; done_exp[k] = 1; rng_exp[k] = fmax(k) - fmin(k);
      end
    end
  endtask

  task automatic check_all();
    chk("busy4", busy4, in_frame[0]); chk("done4", done4, done_exp[0]);
    chk("gmin4", gmin4, fmin(0));     chk("gmax4", gmax4, fmax(0));
    chk("rng4",  rng4,  rng_exp[0]);  chk("cnt4",  cnt4,  nvals[0] / 2);
    chk("busy1", busy1, in_frame[1]); chk("done1", done1, done_exp[1]);
    chk("gmin1", gmin1, fmin(1));     chk("gmax1", gmax1, fmax(1));
    chk("rng1",  rng1,  rng_exp[1]);  chk("cnt1",  cnt1,  nvals[1] / 2);
  endtask

  // one clock: apply inputs, take the edge, advance model, sample 1ns later
  task automatic cyc(input bit r, input bit s, input bit v, input int a, input int b);
    rst = r; start = s; in_valid = v; in_min = 6'(a); in_max = 6'(b);
    @(posedge clk);
    model(0, 4, r, s, v, a, b);
    model(1, 1, r, s, v, a, b);
    #1;
    check_all();
  endtask

  task automatic rnd_cyc(input bit r);
    cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
  endtask

  int pa[4] = '{3, 1, 5, 2};
  int pb[4] = '{10, 7, 63, 2};

  initial begin
    rst = 0; start = 0; in_valid = 0; in_min = 0; in_max = 0;
    #2;
    // 1: reset with random inputs
    rnd_cyc(0); rnd_cyc(0);
    chk("t1_gmin", gmin4, 63); chk("t1_rng", rng4, 0);

    // 2: back-to-back frame
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 9, 9);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, pa[i], pb[i]);
    chk("t2_done", done4, 1);  chk("t2_gmin", gmin4, 1);
    chk("t2_gmax", gmax4, 63); chk("t2_rng", rng4, 62); chk("t2_cnt", cnt4, 4);
    cyc(1, 0, 0, 0, 0);
    chk("t2_done_drop", done4, 0);

    // 3: same pairs with gaps
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int g = int'($urandom_range(0, 3));
      for (int j = 0; j < g; j++) cyc(1, 1'($urandom_range(0, 1)), 0, 50, 60);
      cyc(1, 0, 1, pa[i], pb[i]);
    end
    chk("t3_rng", rng4, 62);
    cyc(1, 0, 0, 0, 0);

    // 4: single swapped pair, N=1
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 40, 5);
    chk("t4_done1", done1, 1); chk("t4_gmin1", gmin1, 5);
    chk("t4_gmax1", gmax1, 40); chk("t4_rng1", rng1, 35);
    cyc(1, 0, 0, 0, 0);

    // 5: reset mid-frame, then clean frame
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 20, 30); cyc(1, 0, 1, 10, 12);
    cyc(0, 0, 1, 1, 2);
    chk("t5_busy", busy4, 0); chk("t5_cnt", cnt4, 0); chk("t5_gmin", gmin4, 63);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, pb[i], pa[i]);
    chk("t5_rng", rng4, 62);

    // 6: start during ACCUM and DONE, then second frame straight after
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 30, 31); cyc(1, 1, 0, 0, 0); cyc(1, 1, 1, 32, 33);
    cyc(1, 0, 1, 34, 35); cyc(1, 0, 1, 36, 37);
    chk("t6_rng", rng4, 7);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t6_gmin", gmin4, 63); chk("t6_gmax", gmax4, 0); chk("t6_busy", busy4, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8 + i, 20 - i);
    chk("t6_rng2", rng4, 12);

    // random tail with occasional reset
    for (int i = 0; i < 200; i++) rnd_cyc(1'($urandom_range(0, 29) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
